pconv_sched: RTL and testbench

//  Sequences one pointwise-conv PE (INPUT_CHANNEL MACs + bias/shift/ReLU) over a whole feature map.

---
 rtl/pconv_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_pconv_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pconv_sched.sv
// ---------------------------------------------------------------------------
// pconv_sched
//   Sequences one pointwise-convolution PE over a whole feature map. The outer
//   loop walks output channels, the inner loop walks pixels. For every channel
//   the weight vector, bias and shift are fetched once and held stable on the
//   pe_* outputs, then pixel vectors are issued one per cycle under a credit
//   limit so the PE results always fit in a small result FIFO that feeds a
//   back-pressured writer.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start / o_busy /    layer-pass handshake (start ignored while busy,
//   o_done                done is a one-cycle pulse after the last write)
//   o_fm_rd_*, i_fm_rd_data  feature-map RAM read (data one cycle later)
//   o_w_rd_*, i_w/b/s_rd_data weight ROM read (data one cycle later)
//   o_pe_*                PE enable, pixel stream and per-channel parameters
//   i_pe_dout(_vld)       PE results, returned in issue order
//   o_out_wr_*, i_out_ready  result writer, transfer on en && ready
// ---------------------------------------------------------------------------
module pconv_sched #(
    parameter int N              = 16,
    parameter int INPUT_CHANNEL  = 3,
    parameter int OUTPUT_CHANNEL = 8,
    parameter int IMG_PIXELS     = 784,
    parameter int FIFO_DEPTH     = 4,
    localparam int PIX_AW = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1,
    localparam int OC_AW  = (OUTPUT_CHANNEL > 1) ? $clog2(OUTPUT_CHANNEL) : 1,
    localparam int OUT_AW = (OUTPUT_CHANNEL * IMG_PIXELS > 1) ?
                            $clog2(OUTPUT_CHANNEL * IMG_PIXELS) : 1,
    localparam int VEC_W  = INPUT_CHANNEL * N
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_fm_rd_en,
    output logic [PIX_AW-1:0] o_fm_rd_addr,
    input  logic [VEC_W-1:0]  i_fm_rd_data,
    output logic              o_w_rd_en,
    output logic [OC_AW-1:0]  o_w_rd_addr,
    input  logic [VEC_W-1:0]  i_w_rd_data,
    input  logic [31:0]       i_b_rd_data,
    input  logic [4:0]        i_s_rd_data,
    output logic              o_pe_ce,
    output logic              o_pe_input_vld,
    output logic [VEC_W-1:0]  o_pe_input_din,
    output logic [VEC_W-1:0]  o_pe_weight_din,
    output logic [31:0]       o_pe_bias,
    output logic [4:0]        o_pe_shift,
    input  logic [N-1:0]      i_pe_dout,
    input  logic              i_pe_dout_vld,
    output logic              o_out_wr_en,
    output logic [OUT_AW-1:0] o_out_wr_addr,
    output logic [N-1:0]      o_out_wr_data,
    input  logic              i_out_ready
);

    localparam int PIX_CW = $clog2(IMG_PIXELS + 1);   // counts 0..IMG_PIXELS
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LATCH_W,
        S_RUN,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [OC_AW-1:0]    r_oc;
    logic [PIX_CW-1:0]   r_pix;
    logic [CNT_W-1:0]    r_inflight;
    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [OUT_AW-1:0]   r_res_addr;
    logic                r_pe_input_vld;
    logic [VEC_W-1:0]    r_pe_weight;
    logic [31:0]         r_pe_bias;
    logic [4:0]          r_pe_shift;

    logic [OUT_AW-1:0]   r_fifo_addr [FIFO_DEPTH];
    logic [N-1:0]        r_fifo_data [FIFO_DEPTH];

    logic                w_issue;
    logic                w_credit_ok;
    logic                w_push;
    logic                w_pop;
    logic                w_last_oc;
    logic                w_all_issued;

    // Credit covers results still inside the PE plus results already queued,
    // so a PE result can never arrive to a FIFO that has no room for it.
    assign w_credit_ok  = ((CNT_W+1)'(r_inflight) + (CNT_W+1)'(r_count))
                          < (CNT_W+1)'(FIFO_DEPTH);
    assign w_all_issued = (r_pix == PIX_CW'(IMG_PIXELS));
    assign w_issue      = (r_state == S_RUN) && !w_all_issued && w_credit_ok;
    assign w_last_oc    = (r_oc == OC_AW'(OUTPUT_CHANNEL - 1));

    // Results only count while something is outstanding; a stale PE result
    // arriving after a mid-pass reset is dropped rather than queued.
    assign w_push = i_pe_dout_vld && (r_inflight != '0);
    assign w_pop  = (r_count != '0) && i_out_ready;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:    if (i_start) w_next = S_LOAD_W;
            S_LOAD_W:  w_next = S_LATCH_W;
            S_LATCH_W: w_next = S_RUN;
            S_RUN:     if (w_all_issued) w_next = S_FLUSH;
            // The PE parameters must not move while any result is in flight.
            S_FLUSH:   if (r_inflight == '0) w_next = w_last_oc ? S_DRAIN : S_LOAD_W;
            S_DRAIN:   if (r_count == '0) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------ loop counters / PE regs
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_oc           <= '0;
            r_pix          <= '0;
            r_inflight     <= '0;
            r_pe_input_vld <= 1'b0;
            r_pe_weight    <= '0;
            r_pe_bias      <= '0;
            r_pe_shift     <= '0;
        end else begin
            r_pe_input_vld <= w_issue;

            if (r_state == S_IDLE && i_start) begin
                r_oc  <= '0;
                r_pix <= '0;
            end else if (w_issue) begin
                r_pix <= r_pix + PIX_CW'(1);
            end else if (r_state == S_FLUSH && r_inflight == '0 && !w_last_oc) begin
                r_oc  <= r_oc + OC_AW'(1);
                r_pix <= '0;
            end

            if (r_state == S_LATCH_W) begin
                r_pe_weight <= i_w_rd_data;
                r_pe_bias   <= i_b_rd_data;
                r_pe_shift  <= i_s_rd_data;
            end

            unique case ({w_issue, w_push})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------ result FIFO
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_res_addr <= '0;
        end else begin
            if (r_state == S_IDLE && i_start) r_res_addr <= '0;
            else if (w_push)                 r_res_addr <= r_res_addr + OUT_AW'(1);

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by r_count,
    // so stale entries are never visible and the array maps onto plain RAM.
    // A push into a full FIFO with a simultaneous pop overwrites the head slot
    // only after its value has been presented to the writer this cycle.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_res_addr;
            r_fifo_data[r_wr_ptr] <= i_pe_dout;
        end
    end

    assert property (@(posedge i_clk) disable iff (i_rst)
                     !(w_push && !w_pop && r_count == CNT_W'(FIFO_DEPTH)));

    // ---------------------------------------------------------------- outputs
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign o_pe_ce         = o_busy;
    assign o_fm_rd_en      = w_issue;
    assign o_fm_rd_addr    = r_pix[PIX_AW-1:0];
    assign o_w_rd_en       = (r_state == S_LOAD_W);
    assign o_w_rd_addr     = r_oc;
    assign o_pe_input_vld  = r_pe_input_vld;
    assign o_pe_input_din  = r_pe_input_vld ? i_fm_rd_data : '0;
    assign o_pe_weight_din = r_pe_weight;
    assign o_pe_bias       = r_pe_bias;
    assign o_pe_shift      = r_pe_shift;
    assign o_out_wr_en     = (r_count != '0);
    assign o_out_wr_addr   = o_out_wr_en ? r_fifo_addr[r_rd_ptr] : '0;
    assign o_out_wr_data   = o_out_wr_en ? r_fifo_data[r_rd_ptr] : '0;

endmodule

// File: tb/tb_pconv_sched.sv
// ---------------------------------------------------------------------------
// tb_pconv_sched
//   Directed bench for pconv_sched with OUTPUT_CHANNEL=2, IMG_PIXELS=4.
//   Surrounds the scheduler with a feature-map RAM, a weight/bias/shift ROM,
//   a 3-cycle PE model and a writer whose ready is scripted per vector.
//   Each table entry is one full layer pass with hand-computed results.
// ---------------------------------------------------------------------------
module tb_pconv_sched;

    localparam int N   = 16;
    localparam int IC  = 3;
    localparam int OC  = 2;
    localparam int PIX = 4;
    localparam int FD  = 4;
    localparam int VW  = IC * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done;
    logic          fm_rd_en;
    logic [1:0]    fm_rd_addr;
    logic [VW-1:0] fm_rd_data;
    logic          w_rd_en;
    logic [0:0]    w_rd_addr;
    logic [VW-1:0] w_rd_data;
    logic [31:0]   b_rd_data;
    logic [4:0]    s_rd_data;
    logic          pe_ce, pe_input_vld;
    logic [VW-1:0] pe_input_din, pe_weight_din;
    logic [31:0]   pe_bias;
    logic [4:0]    pe_shift;
    logic [N-1:0]  pe_dout;
    logic          pe_dout_vld;
    logic          out_wr_en;
    logic [2:0]    out_wr_addr;
    logic [N-1:0]  out_wr_data;
    logic          out_ready;

    pconv_sched #(
        .N(N), .INPUT_CHANNEL(IC), .OUTPUT_CHANNEL(OC),
        .IMG_PIXELS(PIX), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start),
        .o_busy(busy), .o_done(done),
        .o_fm_rd_en(fm_rd_en), .o_fm_rd_addr(fm_rd_addr), .i_fm_rd_data(fm_rd_data),
        .o_w_rd_en(w_rd_en), .o_w_rd_addr(w_rd_addr), .i_w_rd_data(w_rd_data),
        .i_b_rd_data(b_rd_data), .i_s_rd_data(s_rd_data),
        .o_pe_ce(pe_ce), .o_pe_input_vld(pe_input_vld), .o_pe_input_din(pe_input_din),
        .o_pe_weight_din(pe_weight_din), .o_pe_bias(pe_bias), .o_pe_shift(pe_shift),
        .i_pe_dout(pe_dout), .i_pe_dout_vld(pe_dout_vld),
        .o_out_wr_en(out_wr_en), .o_out_wr_addr(out_wr_addr), .o_out_wr_data(out_wr_data),
        .i_out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------ memories
    logic [VW-1:0] fm_mem [PIX];
    logic [VW-1:0] w_mem  [OC];
    logic [31:0]   b_mem  [OC];
    logic [4:0]    s_mem  [OC];

    always @(posedge clk) begin
        if (fm_rd_en) fm_rd_data <= fm_mem[fm_rd_addr];
        if (w_rd_en) begin
            w_rd_data <= w_mem[w_rd_addr];
            b_rd_data <= b_mem[w_rd_addr];
            s_rd_data <= s_mem[w_rd_addr];
        end
    end

    // ------------------------------------------------------ PE model
    // Products use the weights present at input time; bias/shift are applied
    // at output time, so a parameter change while busy corrupts results.
    function automatic logic signed [63:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] w);
        logic signed [63:0] s;
        s = 0;
        for (int i = 0; i < IC; i++)
            s += 64'($signed(a[i*N +: N])) * 64'($signed(w[i*N +: N]));
        return s;
    endfunction

    function automatic logic [N-1:0] pe_fn(input logic signed [63:0] d,
                                          input logic [31:0] b, input logic [4:0] s);
        logic signed [63:0] acc;
        acc = d + $signed({{32{b[31]}}, b});
        acc = acc >>> s;
        if (acc < 0)     return '0;
        if (acc > 32767) return 16'h7FFF;
        return acc[N-1:0];
    endfunction

    logic [2:0]         pv;
    logic signed [63:0] pd0, pd1, pd2;

    always @(posedge clk) begin
        if (rst) pv <= '0;
        else     pv <= {pv[1:0], pe_input_vld};
        pd0 <= dot(pe_input_din, pe_weight_din);
        pd1 <= pd0;
        pd2 <= pd1;
    end

    assign pe_dout_vld = pv[2];
    assign pe_dout     = pe_fn(pd2, pe_bias, pe_shift);

    // ------------------------------------------------------ monitor
    logic [2:0]   wq_addr [$];
    logic [N-1:0] wq_data [$];
    int           n_issued;
    int           n_done;
    logic [31:0]  prev_b = '0;
    logic [4:0]   prev_s = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_wr_en && out_ready) begin
                wq_addr.push_back(out_wr_addr);
                wq_data.push_back(out_wr_data);
            end
            if (fm_rd_en) n_issued++;
            if (done)     n_done++;
        end
        if (pe_bias !== prev_b || pe_shift !== prev_s) begin
            check("pe_param_change_while_busy", 64'({pv, pe_input_vld}), 64'd0);
            prev_b = pe_bias;
            prev_s = pe_shift;
        end
    end

    // ------------------------------------------------------ stimulus
    typedef struct {
        logic [31:0]        b0;
        logic [4:0]         s0;
        logic [31:0]        b1;
        logic [4:0]         s1;
        int                 mode;   // 0 ready=1, 1 ready low 50 cycles, 2 random ready
        bit                 poke;   // pulse start again while busy
        logic [0:7][N-1:0]  exp;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [31:0] b0, input logic [4:0] s0,
                            input logic [31:0] b1, input logic [4:0] s1);
        b_mem[0] = b0; s_mem[0] = s0;
        b_mem[1] = b1; s_mem[1] = s1;
    endtask

    task automatic run_pass(input int vi, input string tag);
        vec_t v;
        int   cyc;
        v = vecs[vi];
        load_cfg(v.b0, v.s0, v.b1, v.s1);
        wq_addr.delete();
        wq_data.delete();
        n_issued  = 0;
        n_done    = 0;
        start     = 1'b1;
        out_ready = (v.mode != 1);
        tick();
        start = 1'b0;
        cyc   = 0;
        while (cyc < 3000) begin
            if (v.mode == 1 && cyc == 50) begin
                check({tag, "_stall_outstanding"}, 64'(n_issued - wq_data.size()), 64'd4);
                check({tag, "_stall_fm_rd_en"}, 64'(fm_rd_en), 64'd0);
                check({tag, "_stall_busy"}, 64'(busy), 64'd1);
            end
            case (v.mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc >= 50);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = v.poke && (cyc == 4 || cyc == 12);
            tick();
            cyc++;
            if (n_done != 0) break;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check({tag, "_done_seen"}, 64'(n_done != 0), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check({tag, "_done_count"}, 64'(n_done), 64'd1);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_write_count"}, 64'(wq_data.size()), 64'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < wq_data.size()) begin
                check($sformatf("%s_addr%0d", tag, k), 64'(wq_addr[k]), 64'(k));
                check($sformatf("%s_data%0d", tag, k), 64'(wq_data[k]), 64'(v.exp[k]));
            end
        end
    endtask

    initial begin
        // Pixel vectors {c0,c1,c2}; element i sits at bits [i*N +: N].
        int px [PIX][IC] = '{'{1, 2, 3}, '{4, 5, 6}, '{-1, 0, 2}, '{10, 10, 10}};
        int wt [OC][IC]  = '{'{1, 1, 1}, '{2, -1, 3}};
        for (int p = 0; p < PIX; p++)
            for (int i = 0; i < IC; i++) fm_mem[p][i*N +: N] = 16'(px[p][i]);
        for (int o = 0; o < OC; o++)
            for (int i = 0; i < IC; i++) w_mem[o][i*N +: N] = 16'(wt[o][i]);

        // oc0 sums 6,15,1,30; oc1 sums 9,21,4,40.
        vecs[0] = '{b0: 32'd0, s0: 5'd0, b1: 32'd8, s1: 5'd2, mode: 0, poke: 1'b0,
                    exp: '{16'd6, 16'd15, 16'd1, 16'd30, 16'd4, 16'd7, 16'd3, 16'd12}};
        vecs[1] = '{b0: 32'h8000_0001, s0: 5'd0, b1: 32'd0, s1: 5'd0, mode: 0, poke: 1'b0,
                    exp: '{16'd0, 16'd0, 16'd0, 16'd0, 16'd9, 16'd21, 16'd4, 16'd40}};
        vecs[2] = '{b0: 32'd0, s0: 5'd0, b1: 32'd8, s1: 5'd2, mode: 1, poke: 1'b0,
                    exp: '{16'd6, 16'd15, 16'd1, 16'd30, 16'd4, 16'd7, 16'd3, 16'd12}};
        vecs[3] = '{b0: 32'd100, s0: 5'd1, b1: 32'd8, s1: 5'd2, mode: 2, poke: 1'b0,
                    exp: '{16'd53, 16'd57, 16'd50, 16'd65, 16'd4, 16'd7, 16'd3, 16'd12}};
        vecs[4] = '{b0: 32'd0, s0: 5'd0, b1: 32'd8, s1: 5'd2, mode: 0, poke: 1'b1,
                    exp: '{16'd6, 16'd15, 16'd1, 16'd30, 16'd4, 16'd7, 16'd3, 16'd12}};

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;
        n_issued  = 0;
        n_done    = 0;
        load_cfg(32'd0, 5'd0, 32'd0, 5'd0);
        for (int i = 0; i < 3; i++) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({done, fm_rd_en, w_rd_en, out_wr_en, pe_input_vld, pe_ce}), 64'd0);
        check("rst_pe_regs", 64'({pe_bias, pe_shift}), 64'd0);
        rst = 1'b0;
        tick();

        run_pass(0, "T1_basic");
        run_pass(1, "T2_relu");
        run_pass(2, "T3_stall");
        run_pass(3, "T4_params");
        run_pass(4, "T5_restart");

        // T6: reset in the middle of RUN, then a clean pass.
        load_cfg(32'd0, 5'd0, 32'd8, 5'd2);
        n_issued = 0;
        n_done   = 0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("T6_mid_run", 64'(n_issued > 0 && busy), 64'd1);
        rst = 1'b1;
        tick();
        check("T6_busy", 64'(busy), 64'd0);
        check("T6_strobes", 64'({done, fm_rd_en, w_rd_en, out_wr_en, pe_input_vld, pe_ce}), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("T6_no_done", 64'(n_done), 64'd0);
        check("T6_idle_strobes", 64'({busy, out_wr_en, fm_rd_en}), 64'd0);
        run_pass(0, "T6_fresh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
